// File: rtl/soc_system_st_to_mm_pkg.sv
// Shared constants for the stream-to-MM receive FIFO: register addresses,
// STATUS bit positions and the INFO word layout.
package soc_system_st_to_mm_pkg;

   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_INFO   = 2'd1;
   localparam logic [1:0] ADDR_STATUS = 2'd2;

   localparam int LEVEL_LSB = 0;
   localparam int EMPTY_BIT = 16;
   localparam int FULL_BIT  = 17;

   localparam int ERR_LSB = 16;
   localparam int CH_LSB  = 8;

   typedef enum logic {
      SRC_WORD = 1'b0,
      SRC_FIFO = 1'b1
   } rd_src_e;

   // INFO layout matches the write-direction FIFO so software can share decode
   function automatic logic [31:0] pack_info(input logic [7:0] err, input logic [7:0] ch);
      logic [31:0] w;
      w = '0;
      w[ERR_LSB +: 8] = err;
      w[CH_LSB +: 8]  = ch;
      return w;
   endfunction

endpackage

// File: rtl/soc_system_st_to_mm_fifo_if.sv
// Avalon-ST sink plus Avalon-MM read slave bundle of the receive FIFO.
interface soc_system_st_to_mm_fifo_if #(
   parameter int DATA_W = 32,
   parameter int CH_W   = 8,
   parameter int ERR_W  = 8
);
   logic [DATA_W-1:0] avalonst_sink_data;
   logic [CH_W-1:0]   avalonst_sink_channel;
   logic [ERR_W-1:0]  avalonst_sink_error;
   logic              avalonst_sink_valid;
   logic              avalonst_sink_ready;

   logic [1:0]        avalonmm_read_slave_address;
   logic              avalonmm_read_slave_read;
   logic [31:0]       avalonmm_read_slave_readdata;
   logic              avalonmm_read_slave_waitrequest;

   modport slave (
      input  avalonst_sink_data, avalonst_sink_channel, avalonst_sink_error,
             avalonst_sink_valid, avalonmm_read_slave_address, avalonmm_read_slave_read,
      output avalonst_sink_ready, avalonmm_read_slave_readdata, avalonmm_read_slave_waitrequest
   );

   modport master (
      output avalonst_sink_data, avalonst_sink_channel, avalonst_sink_error,
             avalonst_sink_valid, avalonmm_read_slave_address, avalonmm_read_slave_read,
      input  avalonst_sink_ready, avalonmm_read_slave_readdata, avalonmm_read_slave_waitrequest
   );
endinterface

// File: rtl/soc_system_st_to_mm_fifo_storage.sv
// Single-clock FIFO storage with pointers and level; the read port is
// registered so the array maps onto block RAM.
module soc_system_st_to_mm_fifo_storage #(
   parameter int W     = 48,
   parameter int DEPTH = 32,
   parameter int AW    = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  rdata,
   output logic [AW:0]   level,
   output logic          empty,
   output logic          full
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata;
   end

   // Caller never pushes when full nor pops when empty, so a simultaneous
   // push/pop never targets the same address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         rdata  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            rdata  <= mem[rd_ptr];
         end
         if (push && !pop)      level <= level + 1'b1;
         else if (pop && !push) level <= level - 1'b1;
      end
   end

   assign empty = (level == '0);
   assign full  = (level == (AW+1)'(DEPTH));

endmodule

// File: rtl/soc_system_st_to_mm_fifo.sv
// Stream-to-MM receive bridge: buffers Avalon-ST beats and lets the CPU drain
// them through a read-only register window (DATA / INFO / STATUS).
module soc_system_st_to_mm_fifo
   import soc_system_st_to_mm_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CH_W   = 8,
   parameter int ERR_W  = 8,
   parameter int DEPTH  = 32,
   parameter int AW     = 5
) (
   input logic rdclock,
   input logic reset_n,
   soc_system_st_to_mm_fifo_if.slave bus
);

   localparam int W = ERR_W + CH_W + DATA_W;

   logic          push;
   logic          pop;
   logic          rd_accept;
   logic          rd_data_addr;
   logic          empty;
   logic          full;
   logic [AW:0]   level;
   logic [W-1:0]  head;
   logic [31:0]   info_word;
   logic [31:0]   status_word;
   logic [31:0]   rd_word;
   rd_src_e       rd_src;

   assign rd_data_addr = (bus.avalonmm_read_slave_address == ADDR_DATA);

   assign bus.avalonst_sink_ready = reset_n & ~full;
   assign bus.avalonmm_read_slave_waitrequest =
      ~reset_n | (bus.avalonmm_read_slave_read & rd_data_addr & empty);

   assign rd_accept = bus.avalonmm_read_slave_read & ~bus.avalonmm_read_slave_waitrequest;
   assign push      = bus.avalonst_sink_valid & bus.avalonst_sink_ready;
   assign pop       = rd_accept & rd_data_addr;

   soc_system_st_to_mm_fifo_storage #(
      .W     (W),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_storage (
      .clk   (rdclock),
      .rst_n (reset_n),
      .push  (push),
      .pop   (pop),
      .wdata ({bus.avalonst_sink_error, bus.avalonst_sink_channel, bus.avalonst_sink_data}),
      .rdata (head),
      .level (level),
      .empty (empty),
      .full  (full)
   );

   // The RAM output register only moves on a pop, so it doubles as the INFO latch.
   assign info_word = pack_info(8'(head[DATA_W+CH_W +: ERR_W]), 8'(head[DATA_W +: CH_W]));

   always_comb begin
      status_word = '0;
      status_word[LEVEL_LSB +: AW+1] = level;
      status_word[EMPTY_BIT] = empty;
      status_word[FULL_BIT]  = full;
   end

   always_ff @(posedge rdclock or negedge reset_n) begin
      if (!reset_n) begin
         rd_src  <= SRC_WORD;
         rd_word <= '0;
      end else if (rd_accept) begin
         rd_src <= rd_data_addr ? SRC_FIFO : SRC_WORD;
         case (bus.avalonmm_read_slave_address)
            ADDR_INFO:   rd_word <= info_word;
            ADDR_STATUS: rd_word <= status_word;
            default:     rd_word <= '0;
         endcase
      end
   end

   assign bus.avalonmm_read_slave_readdata =
      (rd_src == SRC_FIFO) ? 32'(head[DATA_W-1:0]) : rd_word;

endmodule

// File: tb/tb_soc_system_st_to_mm_fifo.sv
// Scoreboard bench for the stream-to-MM receive FIFO: read stimulus queues the
// expected readdata, a monitor compares each accepted read one cycle later.
module tb_soc_system_st_to_mm_fifo;
   import soc_system_st_to_mm_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   soc_system_st_to_mm_fifo_if #(.DATA_W(32), .CH_W(8), .ERR_W(8)) bus ();

   soc_system_st_to_mm_fifo #(
      .DATA_W (32),
      .CH_W   (8),
      .ERR_W  (8),
      .DEPTH  (32),
      .AW     (5)
   ) dut (
      .rdclock (clk),
      .reset_n (rst_n),
      .bus     (bus)
   );

   int tests = 0;
   int fails = 0;
   logic [31:0] exp_q[$];
   string       name_q[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %08h expected %08h", nm, act, exp);
      end
   endtask

   task automatic timeout_fail(input string nm);
      tests++;
      fails++;
      $display("FAIL %s: timed out waiting for DUT", nm);
   endtask

   // Called at a falling edge; returns at a falling edge after the beat is taken.
   task automatic st_push(input logic [31:0] d, input logic [7:0] ch, input logic [7:0] err);
      bus.avalonst_sink_data    = d;
      bus.avalonst_sink_channel = ch;
      bus.avalonst_sink_error   = err;
      bus.avalonst_sink_valid   = 1'b1;
      for (int i = 0; ; i++) begin
         #1;
         if (bus.avalonst_sink_ready) break;
         if (i == 200) begin
            timeout_fail("push_ready");
            bus.avalonst_sink_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      @(negedge clk);
      bus.avalonst_sink_valid = 1'b0;
   endtask

   task automatic mm_read(input logic [1:0] a, input logic [31:0] exp, input string nm,
                          output int stalls);
      exp_q.push_back(exp);
      name_q.push_back(nm);
      bus.avalonmm_read_slave_address = a;
      bus.avalonmm_read_slave_read    = 1'b1;
      stalls = 0;
      forever begin
         #1;
         if (!bus.avalonmm_read_slave_waitrequest) break;
         stalls++;
         if (stalls > 200) begin
            timeout_fail({nm, "_wait"});
            void'(exp_q.pop_back());
            void'(name_q.pop_back());
            bus.avalonmm_read_slave_read = 1'b0;
            return;
         end
         @(negedge clk);
      end
      @(negedge clk);
      bus.avalonmm_read_slave_read = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
      int s;
      mm_read(a, exp, nm, s);
   endtask

   // Monitor: a read accepted in one cycle is compared at the next falling edge.
   initial begin
      bit pend = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (pend && rst_n) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_read: got %08h expected none",
                        bus.avalonmm_read_slave_readdata);
            end else begin
               check(name_q.pop_front(), bus.avalonmm_read_slave_readdata, exp_q.pop_front());
            end
         end
         pend = rst_n && bus.avalonmm_read_slave_read && !bus.avalonmm_read_slave_waitrequest;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int stalls;
      bus.avalonst_sink_data          = '0;
      bus.avalonst_sink_channel       = '0;
      bus.avalonst_sink_error         = '0;
      bus.avalonst_sink_valid         = 1'b0;
      bus.avalonmm_read_slave_address = '0;
      bus.avalonmm_read_slave_read    = 1'b0;

      repeat (3) @(negedge clk);
      #1;
      check("rst_ready", 32'(bus.avalonst_sink_ready), 32'd0);
      check("rst_waitrequest", 32'(bus.avalonmm_read_slave_waitrequest), 32'd1);
      check("rst_readdata", bus.avalonmm_read_slave_readdata, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rel_ready", 32'(bus.avalonst_sink_ready), 32'd1);
      @(negedge clk);

      rd(ADDR_STATUS, 32'h0001_0000, "status_after_reset");
      rd(ADDR_INFO,   32'h0000_0000, "info_after_reset");

      // Three beats, drained in order, INFO follows each pop
      st_push(32'h1111_1111, 8'h02, 8'h00);
      st_push(32'h2222_2222, 8'h03, 8'h01);
      st_push(32'h3333_3333, 8'h04, 8'h00);
      rd(ADDR_DATA, 32'h1111_1111, "data0");
      rd(ADDR_DATA, 32'h2222_2222, "data1");
      rd(ADDR_INFO, 32'h0001_0300, "info_after_data1");
      rd(ADDR_DATA, 32'h3333_3333, "data2");
      rd(ADDR_INFO, 32'h0000_0400, "info_after_data2");

      // Fill to full
      for (int i = 0; i < 32; i++) st_push(32'hF000_0000 + 32'(i), 8'(i), 8'h00);
      #1;
      check("full_ready_low", 32'(bus.avalonst_sink_ready), 32'd0);
      @(negedge clk);
      rd(ADDR_STATUS, 32'h0002_0020, "status_full");
      rd(ADDR_DATA, 32'hF000_0000, "data_full_pop");
      #1;
      check("ready_after_pop", 32'(bus.avalonst_sink_ready), 32'd1);
      @(negedge clk);
      rd(ADDR_STATUS, 32'h0000_001F, "status_31");
      for (int i = 1; i < 32; i++) rd(ADDR_DATA, 32'hF000_0000 + 32'(i), "data_drain_full");
      rd(ADDR_STATUS, 32'h0001_0000, "status_empty_again");

      // Stalled DATA read on empty, released by a push in the fifth stalled cycle
      fork
         mm_read(ADDR_DATA, 32'hDEAD_BEEF, "data_after_stall", stalls);
         begin
            repeat (4) @(negedge clk);
            st_push(32'hDEAD_BEEF, 8'h00, 8'h00);
         end
      join
      check("empty_stall_cycles", 32'(stalls), 32'd5);

      // Streaming at level 4 with pointer wrap
      for (int i = 0; i < 4; i++) st_push(32'hC000_0000 + 32'(i), 8'h01, 8'h00);
      fork
         for (int i = 4; i < 104; i++) st_push(32'hC000_0000 + 32'(i), 8'h01, 8'h00);
         for (int j = 0; j < 100; j++) rd(ADDR_DATA, 32'hC000_0000 + 32'(j), "data_stream");
      join
      rd(ADDR_STATUS, 32'h0000_0004, "status_stream_level");
      for (int j = 100; j < 104; j++) rd(ADDR_DATA, 32'hC000_0000 + 32'(j), "data_stream_tail");

      // Non-destructive reads interleaved with pushes
      st_push(32'hA1A1_A1A1, 8'h12, 8'h34);
      rd(ADDR_STATUS, 32'h0000_0001, "status_lvl1");
      rd(ADDR_INFO,   32'h0000_0100, "info_stale");
      st_push(32'hA2A2_A2A2, 8'h56, 8'h78);
      rd(ADDR_STATUS, 32'h0000_0002, "status_lvl2");
      rd(2'd3,        32'h0000_0000, "addr3_zero");
      rd(ADDR_DATA,   32'hA1A1_A1A1, "data_a1");
      rd(ADDR_INFO,   32'h0034_1200, "info_a1");
      rd(ADDR_DATA,   32'hA2A2_A2A2, "data_a2");
      rd(ADDR_INFO,   32'h0078_5600, "info_a2");
      rd(ADDR_STATUS, 32'h0001_0000, "status_empty_final");

      // Mid-operation reset
      for (int i = 0; i < 10; i++) st_push(32'h5000_0000 + 32'(i), 8'h09, 8'h00);
      rd(ADDR_STATUS, 32'h0000_000A, "status_lvl10");
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_ready", 32'(bus.avalonst_sink_ready), 32'd0);
      check("midrst_waitrequest", 32'(bus.avalonmm_read_slave_waitrequest), 32'd1);
      check("midrst_readdata", bus.avalonmm_read_slave_readdata, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("midrst_rel_ready", 32'(bus.avalonst_sink_ready), 32'd1);
      @(negedge clk);
      rd(ADDR_STATUS, 32'h0001_0000, "status_after_midrst");
      rd(ADDR_INFO,   32'h0000_0000, "info_after_midrst");

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
